// File: rtl/dsp_pkg.sv
// Shared types and elaboration-time helpers for the DSP barrel shifter.
package dsp_pkg;

   typedef enum logic [1:0] {
      ASL = 2'b00,
      LSL = 2'b01,
      ASR = 2'b10,
      ROL = 2'b11
   } shmode_t;

   // ceil(log2(n)), never below 1, so a shift-amount field always has at least one bit
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   // pipeline stage that hosts mux level k
   function automatic int unsigned stage_of(input int unsigned k, input int unsigned pipe,
                                            input int unsigned shw);
      return (k * pipe) / shw;
   endfunction

   // highest mux level placed in stage s; its output feeds that stage's register
   function automatic int unsigned last_level(input int unsigned s, input int unsigned pipe,
                                              input int unsigned shw);
      int unsigned last;
      last = 0;
      for (int unsigned k = 0; k < shw; k++) begin
         if (stage_of(k, pipe, shw) == s) last = k;
      end
      return last;
   endfunction

endpackage

// File: rtl/pipe_barrel_shift_level.sv
// One combinational mux level of the barrel shifter: shifts by 2^K when sh_bit is set.
module shift_level
   import dsp_pkg::*;
#(
   parameter int unsigned OW = 32,
   parameter int unsigned W  = 16,
   parameter int unsigned K  = 0
) (
   input  logic [OW-1:0] data_in,
   input  logic          sh_bit,
   input  shmode_t       mode,
   output logic [OW-1:0] data_out
);

   localparam int unsigned S = 1 << K;

   logic [W-1:0] lo;
   logic [W-1:0] rot;

   // rotate only ever touches the low W bits; the upper half stays zero in ROL mode
   always_comb begin
      lo  = data_in[W-1:0];
      rot = (lo << S) | (lo >> (W - S));
   end

   // select the shifted value for the current mode, or pass through when the bit is clear
   always_comb begin
      data_out = data_in;
      if (sh_bit) begin
         unique case (mode)
            ASL, LSL: data_out = data_in << S;
            ASR:      data_out = $signed(data_in) >>> S;
            ROL:      data_out = {{(OW-W){1'b0}}, rot};
            default:  data_out = data_in;
         endcase
      end
   end

endmodule

// File: rtl/pipe_barrel.sv
// Pipelined barrel shifter: SHW mux levels spread over PIPE register stages, global stall.
module pipe_barrel
   import dsp_pkg::*;
#(
   parameter  int unsigned W    = 16,
   parameter  int unsigned PIPE = 2,
   localparam int unsigned SHW  = clog2(W),
   localparam int unsigned OW   = 2 * W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   input  logic [SHW-1:0] in_sh,
   input  logic [1:0]     in_mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [OW-1:0]  out_data
);

   logic            advance;
   logic [OW-1:0]   ext;

   // stage registers
   logic [OW-1:0]   data_q  [PIPE];
   logic [SHW-1:0]  sh_q    [PIPE];
   shmode_t         mode_q  [PIPE];
   logic [PIPE-1:0] valid_q;

   // stage register inputs
   logic [OW-1:0]   data_d  [PIPE];
   logic [SHW-1:0]  sh_d    [PIPE];
   shmode_t         mode_d  [PIPE];
   logic [PIPE-1:0] valid_d;

   // mux level inputs/outputs
   logic [OW-1:0]   lvl_in   [SHW];
   logic [OW-1:0]   lvl_out  [SHW];
   logic [SHW-1:0]  lvl_sh   [SHW];
   shmode_t         lvl_mode [SHW];

   assign out_valid = valid_q[PIPE-1];
   assign out_data  = data_q[PIPE-1];
   assign advance   = !(out_valid && !out_ready);
   assign in_ready  = advance;

   // sign-extend for the arithmetic modes, zero-extend for logical shift and rotate
   always_comb begin
      if (shmode_t'(in_mode) == ASL || shmode_t'(in_mode) == ASR) begin
         ext = {{W{in_data[W-1]}}, in_data};
      end else begin
         ext = {{W{1'b0}}, in_data};
      end
   end

   // each level takes its operand from the input, the previous stage register,
   // or the previous level when both levels share a stage
   for (genvar k = 0; k < SHW; k++) begin : g_level
      localparam int unsigned S = stage_of(k, PIPE, SHW);
      if (k == 0) begin : g_head
         assign lvl_in[k]   = ext;
         assign lvl_sh[k]   = in_sh;
         assign lvl_mode[k] = shmode_t'(in_mode);
      end else if (S != stage_of(k - 1, PIPE, SHW)) begin : g_reg
         assign lvl_in[k]   = data_q[S-1];
         assign lvl_sh[k]   = sh_q[S-1];
         assign lvl_mode[k] = mode_q[S-1];
      end else begin : g_chain
         assign lvl_in[k]   = lvl_out[k-1];
         assign lvl_sh[k]   = lvl_sh[k-1];
         assign lvl_mode[k] = lvl_mode[k-1];
      end

      shift_level #(
         .OW (OW),
         .W  (W),
         .K  (k)
      ) u_level (
         .data_in  (lvl_in[k]),
         .sh_bit   (lvl_sh[k][k]),
         .mode     (lvl_mode[k]),
         .data_out (lvl_out[k])
      );
   end

   // each stage register captures the output of the last level placed in that stage
   for (genvar s = 0; s < PIPE; s++) begin : g_stage
      localparam int unsigned L = last_level(s, PIPE, SHW);
      assign data_d[s] = lvl_out[L];
      assign sh_d[s]   = lvl_sh[L];
      assign mode_d[s] = lvl_mode[L];
      if (s == 0) begin : g_v0
         assign valid_d[s] = in_valid;
      end else begin : g_vn
         assign valid_d[s] = valid_q[s-1];
      end
   end

   // all stages move together on advance; a held output freezes the whole pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int unsigned s = 0; s < PIPE; s++) begin
            data_q[s] <= '0;
            sh_q[s]   <= '0;
            mode_q[s] <= ASL;
         end
      end else if (advance) begin
         valid_q <= valid_d;
         for (int unsigned s = 0; s < PIPE; s++) begin
            data_q[s] <= data_d[s];
            sh_q[s]   <= sh_d[s];
            mode_q[s] <= mode_d[s];
         end
      end
   end

endmodule

// File: tb/tb_pipe_barrel.sv
// Self-checking bench for pipe_barrel: directed vectors, streaming, back-pressure,
// reset in flight and a randomized parameter sweep against a behavioural model.
module tb_pipe_barrel;
   import dsp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_data = '0;
   logic [4:0]  in_sh = '0;
   logic [1:0]  in_mode = '0;
   int unsigned sel = 0;

   logic        rdy16, vld16, rdy8, vld8, rdy32, vld32;
   logic [31:0] dat16;
   logic [15:0] dat8;
   logic [63:0] dat32;

   logic        cur_ready, cur_valid;
   logic [63:0] cur_data;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   pipe_barrel #(.W(16), .PIPE(2)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
      .in_data(in_data[15:0]), .in_sh(in_sh[3:0]), .in_mode(in_mode),
      .out_valid(vld16), .out_ready(out_ready), .out_data(dat16));

   pipe_barrel #(.W(8), .PIPE(1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
      .in_data(in_data[7:0]), .in_sh(in_sh[2:0]), .in_mode(in_mode),
      .out_valid(vld8), .out_ready(out_ready), .out_data(dat8));

   pipe_barrel #(.W(32), .PIPE(5)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
      .in_data(in_data), .in_sh(in_sh), .in_mode(in_mode),
      .out_valid(vld32), .out_ready(out_ready), .out_data(dat32));

   always_comb begin
      cur_ready = rdy16;
      cur_valid = vld16;
      cur_data  = {32'd0, dat16};
      case (sel)
         1: begin cur_ready = rdy8;  cur_valid = vld8;  cur_data = {48'd0, dat8}; end
         2: begin cur_ready = rdy32; cur_valid = vld32; cur_data = dat32; end
         default: ;
      endcase
   end

   function automatic int unsigned w_of(input int unsigned s);
      return (s == 1) ? 8 : (s == 2) ? 32 : 16;
   endfunction

   function automatic int unsigned pipe_of(input int unsigned s);
      return (s == 1) ? 1 : (s == 2) ? 5 : 2;
   endfunction

   // reference: extend, then shift the whole value with plain integer arithmetic
   function automatic logic [63:0] model(input int unsigned w, input logic [63:0] d_in,
                                         input int unsigned sh, input logic [1:0] m);
      logic [63:0] mask, omask, d, r;
      longint      sx;
      mask  = (64'd1 << w) - 64'd1;
      omask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
      d     = d_in & mask;
      sx    = d[w-1] ? longint'(d | ~mask) : longint'(d);
      case (m)
         2'b00:   r = 64'(sx << sh);
         2'b01:   r = d << sh;
         2'b10:   r = 64'(sx >>> sh);
         default: r = ((d << sh) | (d >> (w - sh))) & mask;
      endcase
      return r & omask;
   endfunction

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      sel = 0;
      in_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({vld8, vld16, vld32} !== 3'b000) $display("FAIL reset_valid got %b expected 000", {vld8, vld16, vld32});
      else pass_cnt++;
      rst_n = 1'b1;
      #1;
      total_cnt++;
      if (cur_data !== 64'd0) $display("FAIL reset_data got %h expected 0", cur_data);
      else pass_cnt++;
      total_cnt++;
      if ({rdy8, rdy16, rdy32} !== 3'b111) $display("FAIL reset_ready got %b expected 111", {rdy8, rdy16, rdy32});
      else pass_cnt++;
      @(negedge clk);
   endtask

   // one beat on the W=16 instance: checks acceptance, latency and value
   task automatic run_one(input string name, input logic [15:0] d, input logic [3:0] sh,
                          input shmode_t m, input logic [31:0] expv);
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_data = {16'd0, d}; in_sh = {1'b0, sh}; in_mode = m; out_ready = 1'b1;
      #1;
      total_cnt++;
      if (cur_ready !== 1'b1) $display("FAIL %s_accept got %b expected 1", name, cur_ready);
      else pass_cnt++;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (cur_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      total_cnt++;
      if (lat != 2) $display("FAIL %s_latency got %0d expected 2", name, lat);
      else pass_cnt++;
      total_cnt++;
      if (cur_data[31:0] !== expv) $display("FAIL %s_data got %h expected %h", name, cur_data[31:0], expv);
      else pass_cnt++;
   endtask

   task automatic test_modes();
      sel = 0;
      do_reset();
      run_one("asl_abcd_4",  16'hABCD, 4'd4,  ASL, 32'hFFFA_BCD0);
      run_one("asl_1234_c",  16'h1234, 4'd12, ASL, 32'h0123_4000);
      run_one("lsl_abcd_4",  16'hABCD, 4'd4,  LSL, 32'h000A_BCD0);
      run_one("asr_abcd_4",  16'hABCD, 4'd4,  ASR, 32'hFFFF_FABC);
      run_one("asr_7fff_f",  16'h7FFF, 4'd15, ASR, 32'h0000_0000);
      run_one("rol_abcd_4",  16'hABCD, 4'd4,  ROL, 32'h0000_BCDA);
      run_one("rol_8001_1",  16'h8001, 4'd1,  ROL, 32'h0000_0003);
      run_one("asl_8000_0",  16'h8000, 4'd0,  ASL, 32'hFFFF_8000);
      run_one("lsl_8000_0",  16'h8000, 4'd0,  LSL, 32'h0000_8000);
      run_one("asr_8000_0",  16'h8000, 4'd0,  ASR, 32'hFFFF_8000);
      run_one("rol_abcd_0",  16'hABCD, 4'd0,  ROL, 32'h0000_ABCD);
      run_one("lsl_ffff_f",  16'hFFFF, 4'd15, LSL, 32'h7FFF_8000);
      run_one("asl_ffff_f",  16'hFFFF, 4'd15, ASL, 32'hFFFF_8000);
   endtask

   task automatic test_streaming();
      int sent, recv, gaps;
      sel = 0;
      do_reset();
      sent = 0; recv = 0; gaps = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         in_valid = (sent < 16); in_data = 32'd1; in_sh = 5'(sent); in_mode = ASL; out_ready = 1'b1;
         #1;
         if (cur_valid === 1'b1) begin
            total_cnt++;
            if (cur_data[31:0] !== (32'd1 << recv))
               $display("FAIL stream_data_%0d got %h expected %h", recv, cur_data[31:0], 32'd1 << recv);
            else pass_cnt++;
            recv++;
         end else if (recv > 0 && recv < 16) begin
            gaps++;
         end
         if (in_valid && cur_ready) sent++;
      end
      in_valid = 1'b0;
      total_cnt++;
      if (recv != 16) $display("FAIL stream_count got %0d expected 16", recv);
      else pass_cnt++;
      total_cnt++;
      if (gaps != 0) $display("FAIL stream_gaps got %0d expected 0", gaps);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [63:0] exp_q[$];
      logic [63:0] prev_data, e;
      logic        prev_stall;
      int          sent, recv;
      sel = 0;
      do_reset();
      sent = 0; recv = 0; prev_stall = 1'b0; prev_data = '0;
      for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
         @(negedge clk);
         in_valid = (sent < 10); in_data = $urandom; in_sh = 5'($urandom_range(0, 15));
         in_mode = 2'($urandom_range(0, 3)); out_ready = !(cyc >= 6 && cyc <= 8);
         #1;
         if (prev_stall) begin
            total_cnt++;
            if (cur_valid !== 1'b1 || cur_data !== prev_data)
               $display("FAIL bp_hold got %b/%h expected 1/%h", cur_valid, cur_data, prev_data);
            else pass_cnt++;
         end
         if (cyc == 6) begin
            total_cnt++;
            if (cur_ready !== 1'b0) $display("FAIL bp_ready_drop got %b expected 0", cur_ready);
            else pass_cnt++;
         end
         if (cur_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
            total_cnt++;
            if (cur_data !== e) $display("FAIL bp_data_%0d got %h expected %h", recv, cur_data, e);
            else pass_cnt++;
            recv++;
         end
         if (in_valid && cur_ready) begin
            exp_q.push_back(model(16, 64'(in_data), int'(in_sh), in_mode));
            sent++;
         end
         prev_stall = cur_valid && !out_ready;
         prev_data  = cur_data;
      end
      in_valid = 1'b0;
      total_cnt++;
      if (recv != 10 || exp_q.size() != 0)
         $display("FAIL bp_count got %0d/%0d expected 10/0", recv, exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_reset_midflight();
      sel = 0;
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hABCD; in_sh = 5'd4; in_mode = ASL; out_ready = 1'b1;
      @(negedge clk);
      in_data = 32'h1234; in_sh = 5'd12;
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (cur_valid !== 1'b0 || cur_data !== 64'd0)
         $display("FAIL rst_async got %b/%h expected 0/0", cur_valid, cur_data);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total_cnt++;
      if (cur_ready !== 1'b1) $display("FAIL rst_ready got %b expected 1", cur_ready);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total_cnt++;
         if (cur_valid !== 1'b0) $display("FAIL rst_stale_%0d got %b expected 0", i, cur_valid);
         else pass_cnt++;
      end
   endtask

   task automatic test_sweep(input int unsigned s);
      logic [63:0] exp_q[$];
      logic [63:0] prev_data, e, mask;
      logic        prev_stall;
      int          sent, recv, bad, cyc;
      int unsigned w;
      sel = s;
      w = w_of(s);
      mask = (64'd1 << w) - 64'd1;
      for (int unsigned m = 0; m < 4; m++) begin
         do_reset();
         exp_q.delete();
         sent = 0; recv = 0; bad = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
         while (recv < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = 32'($urandom & mask);
            in_sh     = 5'($urandom_range(0, w - 1));
            in_mode   = 2'(m);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall) begin
               total_cnt++;
               if (cur_valid !== 1'b1 || cur_data !== prev_data)
                  $display("FAIL sweep_w%0d_hold got %b/%h expected 1/%h", w, cur_valid, cur_data, prev_data);
               else pass_cnt++;
            end
            total_cnt++;
            if (cur_ready !== !(cur_valid && !out_ready))
               $display("FAIL sweep_w%0d_ready got %b expected %b", w, cur_ready, !(cur_valid && !out_ready));
            else pass_cnt++;
            if (cur_valid && out_ready) begin
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
               total_cnt++;
               if (cur_data !== e)
                  $display("FAIL sweep_w%0d_m%0d_beat%0d got %h expected %h", w, m, recv, cur_data, e);
               else pass_cnt++;
               recv++;
            end
            if (in_valid && cur_ready) begin
               exp_q.push_back(model(w, 64'(in_data), int'(in_sh), 2'(m)));
               sent++;
            end
            prev_stall = cur_valid && !out_ready;
            prev_data  = cur_data;
         end
         in_valid = 1'b0;
         total_cnt++;
         if (recv != 1000) $display("FAIL sweep_w%0d_m%0d_count got %0d expected 1000", w, m, recv);
         else pass_cnt++;
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_modes();
      test_streaming();
      test_backpressure();
      test_reset_midflight();
      test_sweep(1);
      test_sweep(2);
      test_sweep(0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pipe_barrel.md
# pipe_barrel

Parametrised, pipelined barrel shifter for the DSP datapath. It takes a W-bit two's-complement sample, a shift amount and a mode. It returns a 2W-bit result through valid/ready handshakes on both sides. The mux levels are split across PIPE register stages so the shifter closes timing at full clock rate. It sits between the sample/coefficient path and the accumulator, where block-floating-point scaling is applied.

## Interface
- W, default 16: input sample width; must be ≥ 2 and a power of two.
- PIPE, default 2: register stages, 1..$clog2(W); latency in cycles.
- SHW (localparam): $clog2(W), shift-amount width.
- OW (localparam): 2*W, output width.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  W  two's-complement sample.
- in_sh  input  SHW  shift amount, 0..W-1.
- in_mode  input  2  shift mode, encodings under Operation.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts a result.
- out_data  output  OW  shifted result.

## Operation
- Modes:
  - 00 ASL: sign-extend in_data to OW, then shift left by in_sh, zero fill.
  - 01 LSL: zero-extend to OW, then shift left by in_sh.
  - 10 ASR: sign-extend to OW, then shift right arithmetically by in_sh.
  - 11 ROL: rotate in_data left by in_sh within W bits, then zero-extend to OW.
- Transfer rules:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
- Shift network:
  - SHW mux levels; level k shifts by 2^k when in_sh[k] is set, applying the mode.
  - Level k is placed in pipeline stage floor(k*PIPE/SHW).
  - Every stage ends in a register holding data, remaining sh bits, mode and a valid bit.
- Stall is global:
  - advance = !(out_valid && !out_ready).
  - On advance, every stage register loads from the previous stage.
  - The stage-0 valid loads in_valid && in_ready.
  - in_ready = advance (combinational from out_valid and out_ready).
  - Beats are never dropped or duplicated under back-pressure.
- Bubbles (cleared valid bits) propagate and are squeezed out only by advance.
- Reset:
  - All valid bits clear: out_valid=0, out_data=0; in_ready=1 once rst_n=1.
  - Reset mid-operation discards every beat in flight; no partial result is ever presented.

## Timing
- Latency:
  - A beat accepted in cycle n appears at out_valid in cycle n+PIPE when there is no stall.
  - Each stall cycle adds one cycle.
- Throughput is one beat per cycle while out_ready=1.
- While out_valid=1 and out_ready=0:
  - out_data and out_valid stay stable.
  - in_ready=0.
- Simultaneous output accept and input accept in the same cycle is legal and sustains full rate.
- Corner cases:
  - in_sh=0 gives the pure sign- or zero-extended value in every mode; ROL with in_sh=0 gives zero-extended in_data.
  - Maximum shift in_sh=W-1 gives no overflow in ASL/LSL, since OW=2W.

## Structure
- Package dsp_pkg:
  - enum shmode_t {ASL=2'b00, LSL=2'b01, ASR=2'b10, ROL=2'b11}.
  - Function clog2 guard for SHW.
- Sub-module shift_level: one combinational mux level, parameters OW, W and K (shift 2^K), mode-aware.
- pipe_barrel instantiates SHW shift_level instances plus the stage registers and the valid/stall logic.

## Test plan
- Default W=16, PIPE=2, out_ready=1:
  - ASL: ABCD sh 4 → FFFABCD0; 1234 sh C → 01234000.
  - Each result arrives exactly 2 cycles after acceptance.
- Other modes on ABCD sh 4:
  - LSL → 000ABCD0.
  - ASR → FFFFFABC; ASR 7FFF sh F → 00000000.
  - ROL → 0000BCDA; ROL 8001 sh 1 → 00000003.
- Streaming: 16 back-to-back beats with in_sh=0..15 in ASL on 0001.
  - out_data=1<<k in order.
  - No gaps.
- Back-pressure:
  - Drop out_ready for 3 cycles mid-stream.
  - in_ready falls the same cycle; out_data is held stable.
  - All beats are delivered once, in order, after release.
- Reset:
  - Assert rst_n=0 asynchronously with 2 beats in flight.
  - out_valid=0 immediately; no stale beat emerges after release.
  - in_ready=1 on the first cycle after release.
- Parameter sweep W=8 PIPE=1 and W=32 PIPE=5, against a reference model, 1000 random beats with random out_ready per mode.
